// File: rtl/mat_row_reader.sv
// -----------------------------------------------------------------------------
// mat_row_reader
//
// Read-side initiator for the matrix row memory. A start command latches a
// base row address and a row count, then the block issues sequential row
// reads over the memory en/rw/address port, captures each returned row in a
// small FIFO and streams the rows, in order, to the compute datapath.
//
// Reads are credit controlled: a read is only issued when the rows already in
// flight plus the rows sitting in the FIFO leave room for its data, so the
// FIFO can never overflow regardless of downstream back-pressure.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            command strobe, accepted only while busy_o = 0
//   base_addr_i        first row address of the command
//   row_count_i        number of rows (0 = empty command, done only)
//   busy_o             command in progress
//   done_o             one-cycle completion pulse
//   mem_en_o           memory enable, high only in read-request cycles
//   mem_rw_o           constant 1 (read)
//   mem_addr_o         read row address
//   mem_data_o         write data, constant 0
//   mem_data_i         read data, valid RD_LAT cycles after the request
//   row_data_o         head row of the FIFO
//   row_valid_o        row_data_o is valid
//   row_ready_i        downstream accepts the row
//   row_last_o         head row is the final row of the command
//   dbg_state_o        current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN)
//
// Stream handshake: a row transfers in any cycle where row_valid_o and
// row_ready_i are both 1. While row_valid_o = 1 and row_ready_i = 0 the
// row_data_o / row_last_o pair holds stable; row_valid_o never drops without
// a transfer.
// -----------------------------------------------------------------------------
module mat_row_reader #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] row_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] row_data_o,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic              row_last_o,
  output logic [1:0]        dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for in-flight reads plus buffered rows.
  localparam int CR_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]   deliver_cnt_q, deliver_cnt_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   inflight_q, inflight_d;

  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;

  logic [CR_W-1:0]     inflight_cnt;
  logic [CR_W-1:0]     credit_used;
  logic                issue;
  logic                ret;
  logic                pop;
  logic                last_xfer;

  // ---------------------------------------------------------------------------
  // Credit and handshake terms
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CR_W'(inflight_q[i]);
    end
  end

  assign credit_used = inflight_cnt + CR_W'(fifo_cnt_q);
  assign issue       = (state_q == S_ISSUE) && (credit_used < CR_W'(FIFO_DEPTH));
  // Oldest in-flight slot: its data is on mem_data_i this cycle.
  assign ret         = inflight_q[RD_LAT-1];
  assign row_valid_o = (fifo_cnt_q != '0);
  assign pop         = row_valid_o && row_ready_i;
  // deliver_cnt only moves on a transfer, so row_last_o is stable under stall.
  assign row_last_o  = row_valid_o && (deliver_cnt_q == ADDR_W'(1));
  assign last_xfer   = pop && (deliver_cnt_q == ADDR_W'(1));

  // In-flight shift register: slot 0 is the request cycle's tag.
  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = pop ? (deliver_cnt_q - ADDR_W'(1)) : deliver_cnt_q;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (row_count_i != '0) begin
            state_d       = S_ISSUE;
            addr_d        = base_addr_i;
            issue_cnt_d   = row_count_i;
            deliver_cnt_d = row_count_i;
          end else begin
            // Empty command: completion pulse only, never busy, no access.
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          issue_cnt_d = issue_cnt_q - ADDR_W'(1);
          if (issue_cnt_q == ADDR_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The final row always follows the final issue by at least
        // RD_LAT + 1 cycles, so the last transfer can only happen here.
        if (last_xfer) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      done_q        <= 1'b0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      done_q        <= done_d;
      inflight_q    <= inflight_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO. Credit control guarantees a write never meets a full FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (ret) begin
        fifo_mem_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({ret, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign mem_en_o    = issue;
  assign mem_rw_o    = 1'b1;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = '0;
  assign row_data_o  = fifo_mem_q[rd_ptr_q];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mat_row_reader.sv
module tb_mat_row_reader;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [ADDR_W-1:0] row_count_i = '0;
  logic              busy_o, done_o, mem_en_o, mem_rw_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic [DATA_W-1:0] row_data_o;
  logic              row_valid_o, row_last_o;
  logic              row_ready_i = 1'b0;
  logic [1:0]        dbg_state_o;

  mat_row_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .row_count_i (row_count_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_en_o    (mem_en_o),
    .mem_rw_o    (mem_rw_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .row_data_o  (row_data_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .row_last_o  (row_last_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (1-cycle read latency) ----------------
  function automatic logic [DATA_W-1:0] mem_val(input int a);
    if (a >= 8 && a <= 11) return DATA_W'(1329 + a);
    return {8{8'(a), 24'hC3A51E}};
  endfunction

  logic [DATA_W-1:0] mem_arr [256];
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = mem_val(i);
  end

  always @(posedge clk) begin
    if (mem_en_o && mem_rw_o) mem_data_i <= mem_arr[mem_addr_o];
  end

  // ---------------- monitor ----------------
  logic [ADDR_W-1:0] addr_q [$];
  int                en_cyc_q [$];
  logic [DATA_W-1:0] row_q [$];
  logic              last_q [$];
  int                valid_cyc_q [$];
  int                done_cyc_q [$];
  int                busy_cyc_q [$];
  int                en_idle_cnt = 0;
  int                tie_bad = 0;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (mem_en_o) begin
        addr_q.push_back(mem_addr_o);
        en_cyc_q.push_back(cyc);
      end
      if (row_valid_o && row_ready_i) begin
        row_q.push_back(row_data_o);
        last_q.push_back(row_last_o);
      end
      if (row_valid_o) valid_cyc_q.push_back(cyc);
      if (done_o) done_cyc_q.push_back(cyc);
      if (busy_o) busy_cyc_q.push_back(cyc);
      if (mem_en_o && !busy_o) en_idle_cnt <= en_idle_cnt + 1;
      if (mem_rw_o !== 1'b1 || mem_data_o !== '0) tie_bad <= tie_bad + 1;
    end
  end

  // ---------------- scoreboard / checks ----------------
  logic [DATA_W-1:0] exp_q [$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mon();
    addr_q.delete();
    en_cyc_q.delete();
    row_q.delete();
    last_q.delete();
    valid_cyc_q.delete();
    done_cyc_q.delete();
    busy_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt, output int t0);
    start_i     = 1'b1;
    base_addr_i = base;
    row_count_i = cnt;
    t0          = cyc;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cyc_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cyc_q.size() == 0) chki({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic check_stream(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_val((base + i) % 256));
    chki({tag, "_addr_count"}, addr_q.size(), n);
    chki({tag, "_row_count"}, row_q.size(), n);
    for (int i = 0; i < n && i < addr_q.size(); i++)
      chki({tag, "_addr"}, int'(addr_q[i]), (base + i) % 256);
    for (int i = 0; i < n && i < row_q.size(); i++) begin
      chk({tag, "_row"}, row_q[i], exp_q[i]);
      chk1({tag, "_last"}, last_q[i], i == n - 1);
    end
    chki({tag, "_done_count"}, done_cyc_q.size(), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_done"}, done_o, 1'b0);
    chk1({tag, "_mem_en"}, mem_en_o, 1'b0);
    chk1({tag, "_mem_rw"}, mem_rw_o, 1'b1);
    chk({tag, "_mem_addr"}, DATA_W'(mem_addr_o), '0);
    chk1({tag, "_row_valid"}, row_valid_o, 1'b0);
    chk1({tag, "_row_last"}, row_last_o, 1'b0);
    chk({tag, "_row_data"}, row_data_o, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int n;
    int rows_at_rst;

    // Reset
    rst_i = 1'b1;
    ticks(3);
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // Basic read: rows 8..11 = 1337..1340
    clear_mon();
    row_ready_i = 1'b1;
    start_cmd(8'd8, 8'd4, t0);
    chk1("basic_busy_T1", busy_o, 1'b1);
    chk1("basic_en_T1", mem_en_o, 1'b1);
    chk("basic_addr_T1", DATA_W'(mem_addr_o), DATA_W'(8));
    wait_done("basic", 40);
    ticks(3);
    chk("basic_row0_is_1337", row_q.size() > 0 ? row_q[0] : '1, DATA_W'(1337));
    chki("basic_first_valid_cyc", valid_cyc_q.size() > 0 ? valid_cyc_q[0] - t0 : -1, 3);
    chki("basic_done_cyc", done_cyc_q.size() > 0 ? done_cyc_q[0] - t0 : -1, 7);
    for (int i = 0; i < en_cyc_q.size(); i++) chki("basic_en_cyc", en_cyc_q[i] - t0, i + 1);
    check_stream("basic", 8, 4);
    chk1("basic_busy_after", busy_o, 1'b0);

    // Back-pressure: 8 rows, ready low for 20 cycles
    clear_mon();
    row_ready_i = 1'b0;
    start_cmd(8'h20, 8'd8, t0);
    ticks(5);
    chk("bp_hold_early", row_data_o, mem_val(8'h20));
    ticks(14);
    chki("bp_issued_stalled", addr_q.size(), 4);
    chk1("bp_valid_stalled", row_valid_o, 1'b1);
    chk1("bp_last_stalled", row_last_o, 1'b0);
    chk("bp_hold_late", row_data_o, mem_val(8'h20));
    chk1("bp_busy_stalled", busy_o, 1'b1);
    row_ready_i = 1'b1;
    wait_done("bp", 60);
    ticks(3);
    check_stream("bp", 8'h20, 8);

    // Wrap-around
    clear_mon();
    start_cmd(8'hFE, 8'd4, t0);
    wait_done("wrap", 40);
    ticks(3);
    check_stream("wrap", 8'hFE, 4);

    // Zero count
    clear_mon();
    start_cmd(8'h33, 8'd0, t0);
    chk1("zero_done_pulse", done_o, 1'b1);
    chk1("zero_busy", busy_o, 1'b0);
    ticks(4);
    chk1("zero_done_single", done_o, 1'b0);
    chki("zero_no_access", addr_q.size(), 0);
    chki("zero_never_busy", busy_cyc_q.size(), 0);
    chki("zero_done_count", done_cyc_q.size(), 1);
    chki("zero_done_cyc", done_cyc_q.size() > 0 ? done_cyc_q[0] - t0 : -1, 1);

    // Start while busy is ignored
    clear_mon();
    start_cmd(8'h40, 8'd3, t0);
    start_i     = 1'b1;
    base_addr_i = 8'h80;
    row_count_i = 8'd5;
    tick();
    start_i = 1'b0;
    wait_done("busy_start", 40);
    ticks(5);
    check_stream("busy_start", 8'h40, 3);

    // Random ready, 255 rows
    clear_mon();
    start_cmd(8'h10, 8'd255, t0);
    n = 0;
    while (done_cyc_q.size() == 0 && n < 3000) begin
      row_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    row_ready_i = 1'b1;
    if (done_cyc_q.size() == 0) chki("rand_done_timeout", 0, 1);
    ticks(3);
    check_stream("rand", 8'h10, 255);

    // Reset mid-command
    clear_mon();
    start_cmd(8'h50, 8'd10, t0);
    n = 0;
    while (row_q.size() < 2 && n < 40) begin
      tick();
      n++;
    end
    chk1("midrst_two_rows_seen", row_q.size() >= 2, 1'b1);
    rst_i = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    rows_at_rst = row_q.size();
    ticks(6);
    chki("midrst_no_done", done_cyc_q.size(), 0);
    chki("midrst_no_rows", row_q.size(), rows_at_rst);
    chk1("midrst_idle", busy_o, 1'b0);

    clear_mon();
    start_cmd(8'h60, 8'd3, t0);
    wait_done("after_rst", 40);
    ticks(3);
    check_stream("after_rst", 8'h60, 3);

    // Global properties
    chki("en_outside_issue", en_idle_cnt, 0);
    chki("rw_and_wdata_tied", tie_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
